// File: rtl/music_box_pkg.sv
// Shared encodings and constants for the music box record/playback states.
// The playback block imports the same sample count so both agree on length.
package music_box_pkg;

    localparam logic [4:0] PLAYBACK_STATE = 5'd1;
    localparam logic [4:0] RECORD_STATE   = 5'd2;

    localparam int SAMPLES_PER_SECOND     = 22050;
    localparam int RECORD_SECONDS         = 5;
    localparam int RECORD_SAMPLES_DEFAULT = SAMPLES_PER_SECOND * RECORD_SECONDS;

    localparam int COUNT_W  = 19;
    localparam int ADDR_W   = 25;
    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        REC_IDLE    = 3'd0,
        REC_CAPTURE = 3'd1,
        REC_DONE    = 3'd2,
        REC_FAIL    = 3'd3
    } record_state_t;

endpackage

// File: rtl/music_box_state_record_sdram_if.sv
// Command bus between a requesting state block and the shared SDRAM controller.
interface music_box_state_record_sdram_if;
    import music_box_pkg::*;

    logic [ADDR_W-1:0]   inputAddress;
    logic [SAMPLE_W-1:0] writeData;
    logic                isWriting;
    logic                inputValid;
    logic                recievedCommand;
    logic                isBusy;

    modport master (
        output inputAddress, writeData, isWriting, inputValid,
        input  recievedCommand, isBusy
    );

    modport slave (
        input  inputAddress, writeData, isWriting, inputValid,
        output recievedCommand, isBusy
    );

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// A push into a full FIFO is only honoured when a pop happens in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock_50Mhz,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clock_50Mhz) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/music_box_state_record_sdram.sv
// Recording state: buffers strobed audio samples and streams them as SDRAM
// writes to consecutive addresses, reporting completion or FIFO overflow.
module music_box_state_record_sdram #(
    parameter logic [4:0]  RECORD_STATE   = 5'd2,
    parameter int          RECORD_SAMPLES = 110250,
    parameter logic [24:0] BASE_ADDR      = 25'd0,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        clock_50Mhz,
    input  logic        reset_n,
    input  logic [4:0]  mainState,
    input  logic        sample_strobe,
    input  logic [15:0] inputData,
    output logic        stateComplete,
    output logic        stateFailed,
    output logic [31:0] debugString,
    music_box_state_record_sdram_if.master sdram
);
    import music_box_pkg::*;

    localparam logic [COUNT_W-1:0] SAMPLE_LIMIT = COUNT_W'(RECORD_SAMPLES);

    record_state_t       state_reg,    state_next;
    logic [COUNT_W-1:0]  captured_reg, captured_next;
    logic [COUNT_W-1:0]  written_reg,  written_next;
    logic                valid_reg,    valid_next;
    logic                writing_reg,  writing_next;
    logic [ADDR_W-1:0]   addr_reg,     addr_next;
    logic [SAMPLE_W-1:0] data_reg,     data_next;

    logic                in_record;
    logic                capturing;
    logic                accept;
    logic                want_push;
    logic                overflow;
    logic                fifo_push;
    logic                fifo_rst_n;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_dout;

    assign in_record = (mainState == RECORD_STATE);
    assign capturing = (state_reg == REC_CAPTURE);
    assign accept    = capturing && valid_reg && sdram.recievedCommand;
    assign want_push = capturing && sample_strobe && (captured_reg < SAMPLE_LIMIT);
    // The in-flight sample stays in the FIFO until accepted, so a pop frees room.
    assign overflow  = want_push && fifo_full && !accept;
    assign fifo_push = want_push && !overflow;
    // Leaving the record state flushes any buffered samples.
    assign fifo_rst_n = reset_n && in_record;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (fifo_rst_n),
        .push        (fifo_push),
        .pop         (accept),
        .din         (inputData),
        .dout        (fifo_dout),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    always_comb begin
        state_next    = state_reg;
        captured_next = captured_reg;
        written_next  = written_reg;
        valid_next    = valid_reg;
        writing_next  = writing_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;

        if (!in_record) begin
            state_next    = REC_IDLE;
            captured_next = '0;
            written_next  = '0;
            valid_next    = 1'b0;
            writing_next  = 1'b0;
            addr_next     = '0;
            data_next     = '0;
        end else begin
            case (state_reg)
                REC_IDLE: begin
                    state_next = REC_CAPTURE;
                end
                REC_CAPTURE: begin
                    if (fifo_push) begin
                        captured_next = captured_reg + 1'b1;
                    end
                    if (accept) begin
                        valid_next   = 1'b0;
                        writing_next = 1'b0;
                        written_next = written_reg + 1'b1;
                        if (written_reg + 1'b1 == SAMPLE_LIMIT) begin
                            state_next = REC_DONE;
                        end
                    end else if (!valid_reg && !fifo_empty && !sdram.isBusy) begin
                        valid_next   = 1'b1;
                        writing_next = 1'b1;
                        addr_next    = BASE_ADDR + {{(ADDR_W - COUNT_W){1'b0}}, written_reg};
                        data_next    = fifo_dout;
                    end
                    if (overflow) begin
                        state_next   = REC_FAIL;
                        valid_next   = 1'b0;
                        writing_next = 1'b0;
                    end
                end
                default: begin
                    valid_next   = 1'b0;
                    writing_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            state_reg    <= REC_IDLE;
            captured_reg <= '0;
            written_reg  <= '0;
            valid_reg    <= 1'b0;
            writing_reg  <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            captured_reg <= captured_next;
            written_reg  <= written_next;
            valid_reg    <= valid_next;
            writing_reg  <= writing_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
        end
    end

    assign sdram.inputAddress = addr_reg;
    assign sdram.writeData    = data_reg;
    assign sdram.isWriting    = writing_reg;
    assign sdram.inputValid   = valid_reg;

    assign stateComplete = (state_reg == REC_DONE);
    assign stateFailed   = (state_reg == REC_FAIL);
    assign debugString   = {stateFailed, state_reg, 9'b0, addr_reg[18:0]};

endmodule

// File: tb/tb_music_box_state_record_sdram.sv
// Randomised bench for the recording state: a queue-based model of captured
// samples predicts the SDRAM write stream, completion and overflow.
module tb_music_box_state_record_sdram;

    localparam logic [4:0]  REC   = 5'd2;
    localparam int          N     = 8;
    localparam logic [24:0] BASE  = 25'h01_ABC0;
    localparam int          DEPTH = 4;

    localparam int ST_IDLE = 0;
    localparam int ST_CAP  = 1;
    localparam int ST_DONE = 2;
    localparam int ST_FAIL = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  main_state;
    logic        strobe;
    logic [15:0] in_data;
    logic        complete;
    logic        failed;
    logic [31:0] debug;

    music_box_state_record_sdram_if bus();

    always #5 clk = ~clk;

    music_box_state_record_sdram #(
        .RECORD_STATE   (REC),
        .RECORD_SAMPLES (N),
        .BASE_ADDR      (BASE),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock_50Mhz   (clk),
        .reset_n       (reset_n),
        .mainState     (main_state),
        .sample_strobe (strobe),
        .inputData     (in_data),
        .stateComplete (complete),
        .stateFailed   (failed),
        .debugString   (debug),
        .sdram         (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: what has been captured but not yet written, and
    // whether a write command should currently be on the bus.
    int          m_state = ST_IDLE;
    logic [15:0] pending[$];
    int          pushed  = 0;
    int          written = 0;
    bit          m_valid = 1'b0;

    int hold_req    = 2;
    int vcnt        = 0;
    bit sync_strobe = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [24:0] exp_addr;
        exp_addr = BASE + 25'(written);
        check("complete", 32'(complete), 32'(m_state == ST_DONE));
        check("failed", 32'(failed), 32'(m_state == ST_FAIL));
        check("dbg_fail", 32'(debug[31]), 32'(m_state == ST_FAIL));
        check("valid", 32'(bus.inputValid), 32'(m_valid));
        if (m_state == ST_IDLE) begin
            check("idle_addr", 32'(bus.inputAddress), 32'd0);
            check("idle_data", 32'(bus.writeData), 32'd0);
            check("idle_wr", 32'(bus.isWriting), 32'd0);
            check("idle_dbg", debug, 32'd0);
        end
        if (m_valid) begin
            check("addr", 32'(bus.inputAddress), 32'(exp_addr));
            check("data", 32'(bus.writeData), 32'(pending[0]));
            check("writing", 32'(bus.isWriting), 32'd1);
            check("dbg_addr", 32'(debug[18:0]), 32'(exp_addr[18:0]));
        end
    endtask

    task automatic model_edge(input bit stb, input logic [15:0] d, input bit busy, input bit recv);
        bit acc;
        bit nv;
        int occ;
        if (!reset_n || main_state != REC) begin
            m_state = ST_IDLE;
            pending.delete();
            pushed  = 0;
            written = 0;
            m_valid = 1'b0;
            return;
        end
        case (m_state)
            ST_IDLE: m_state = ST_CAP;
            ST_CAP: begin
                acc = m_valid && recv;
                occ = pending.size();
                if (acc) begin
                    void'(pending.pop_front());
                    written++;
                    nv = 1'b0;
                    if (written == N) m_state = ST_DONE;
                end else if (m_valid) begin
                    nv = 1'b1;
                end else begin
                    nv = (occ > 0) && !busy;
                end
                if (stb && pushed < N) begin
                    if (occ == DEPTH && !acc) begin
                        m_state = ST_FAIL;
                        nv      = 1'b0;
                    end else begin
                        pending.push_back(d);
                        pushed++;
                    end
                end
                m_valid = nv;
            end
            default: m_valid = 1'b0;
        endcase
    endtask

    // One clock: check at the falling edge, act as controller, then advance the model.
    task automatic tick(input bit stb, input logic [15:0] d, input bit busy);
        bit recv;
        bit s;
        check_outputs();
        vcnt = bus.inputValid ? vcnt + 1 : 0;
        recv = bus.inputValid && (vcnt >= hold_req);
        s    = stb || (sync_strobe && recv);
        strobe              = s;
        in_data             = d;
        bus.isBusy          = busy;
        bus.recievedCommand = recv;
        @(posedge clk);
        model_edge(s, d, busy, recv);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles, input bit busy);
        for (int i = 0; i < cycles; i++) tick(1'b0, 16'($urandom), busy);
    endtask

    task automatic leave_and_enter();
        main_state = 5'd0;
        idle(2, 1'b0);
        main_state = REC;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n             = 1'b0;
        main_state          = 5'd0;
        strobe              = 1'b0;
        in_data             = 16'd0;
        bus.isBusy          = 1'b0;
        bus.recievedCommand = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held while the record state is selected.
        main_state = REC;
        idle(3, 1'b0);
        check("rst_valid", 32'(bus.inputValid), 32'd0);
        check("rst_dbg", debug, 32'd0);
        reset_n = 1'b1;

        // 1: full recording, controller echoes valid one cycle later.
        hold_req = 2;
        idle(2, 1'b0);
        for (int n = 0; n < N; n++) begin
            tick(1'b1, 16'h1000 + 16'(n), 1'b0);
            if (n == 0) check("lat1", 32'(bus.inputValid), 32'd0);
            tick(1'b0, 16'($urandom), 1'b0);
            if (n == 0) check("lat2", 32'(bus.inputValid), 32'd1);
            idle(18, 1'b0);
        end
        idle(5, 1'b0);
        check("t1_done", 32'(complete), 32'd1);
        check("t1_nofail", 32'(failed), 32'd0);
        leave_and_enter();

        // 2: long acceptance stall with a second sample queued behind it.
        hold_req = 11;
        idle(2, 1'b0);
        tick(1'b1, 16'($urandom), 1'b0);
        idle(2, 1'b0);
        tick(1'b1, 16'($urandom), 1'b0);
        idle(30, 1'b0);
        hold_req = 2;
        leave_and_enter();

        // 3: controller busy, fifth sample overflows the buffer.
        idle(2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 16'($urandom), 1'b1);
            if (k == 4) begin
                check("t3_fail", 32'(failed), 32'd1);
                check("t3_valid", 32'(bus.inputValid), 32'd0);
            end
            idle(9, 1'b1);
        end
        idle(5, 1'b0);
        check("t3_hold", 32'(failed), 32'd1);
        leave_and_enter();

        // 4: full buffer, every acceptance coincides with a new strobe.
        idle(2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 16'($urandom), 1'b1);
            tick(1'b0, 16'($urandom), 1'b1);
        end
        sync_strobe = 1'b1;
        idle(40, 1'b0);
        sync_strobe = 1'b0;
        check("t4_done", 32'(complete), 32'd1);
        check("t4_nofail", 32'(failed), 32'd0);
        leave_and_enter();

        // 5: leave the record state while a command is outstanding.
        hold_req = 50;
        idle(2, 1'b0);
        tick(1'b1, 16'($urandom), 1'b0);
        idle(3, 1'b0);
        check("t5_pre", 32'(bus.inputValid), 32'd1);
        main_state = 5'd0;
        tick(1'b0, 16'($urandom), 1'b0);
        check("t5_valid", 32'(bus.inputValid), 32'd0);
        check("t5_addr", 32'(bus.inputAddress), 32'd0);
        check("t5_dbg", debug, 32'd0);
        main_state = REC;
        hold_req   = 1;
        idle(2, 1'b0);
        tick(1'b1, 16'($urandom), 1'b0);
        idle(6, 1'b0);

        // 6: one-cycle reset during capture restarts recording.
        tick(1'b1, 16'($urandom), 1'b1);
        idle(2, 1'b1);
        tick(1'b1, 16'($urandom), 1'b1);
        reset_n = 1'b0;
        tick(1'b0, 16'($urandom), 1'b0);
        check("t6_valid", 32'(bus.inputValid), 32'd0);
        check("t6_dbg", debug, 32'd0);
        reset_n = 1'b1;
        idle(2, 1'b0);
        tick(1'b1, 16'($urandom), 1'b0);
        idle(8, 1'b0);
        leave_and_enter();

        // Random recordings: busy bursts, strobe density and stall length vary.
        for (int r = 0; r < 6; r++) begin
            int busy_pct;
            busy_pct = int'($urandom_range(0, 60));
            hold_req = int'($urandom_range(1, 4));
            for (int c = 0; c < 200; c++) begin
                tick($urandom_range(0, 3) == 0, 16'($urandom),
                     int'($urandom_range(0, 99)) < busy_pct);
            end
            leave_and_enter();
        end
        idle(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/music_box_state_record_sdram.md
Name: music_box_state_record_sdram

Overview:
Recording-state counterpart to the SDRAM playback state. While mainState selects recording, it captures one 16-bit audio sample per 22.05 kHz strobe. Samples are buffered in a small FIFO and written to consecutive SDRAM addresses through the shared SDRAM controller's valid/received handshake. It signals stateComplete when the programmed sample count is written, or flags failure on buffer overflow; playback later reads the same address range.

Parameters:
RECORD_STATE, 5'd2, mainState encoding that enables this block
RECORD_SAMPLES, 110250, samples per recording (22050 x 5 s)
BASE_ADDR, 25'd0, SDRAM address of sample 0
FIFO_DEPTH, 4, sample buffer entries (power of 2, >=2)

Ports:
clock_50Mhz  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
mainState  input  5  top-level state from MusicBoxStateController
sample_strobe  input  1  one-cycle pulse at 22.05 kHz, synchronous to clock_50Mhz
inputData  input  16  audio sample, valid when sample_strobe=1
stateComplete  output  1  recording finished successfully
stateFailed  output  1  FIFO overflow occurred; recording aborted
debugString  output  32  {fail, state[2:0], 9'b0, sdram_inputAddress[18:0]}
sdram_inputAddress  output  25  write address
sdram_writeData  output  16  write data
sdram_isWriting  output  1  1 = write command
sdram_inputValid  output  1  command request, active high
sdram_recievedCommand  input  1  controller accepted the command this cycle
sdram_isBusy  input  1  controller cannot accept a new command

Behaviour:
- Reset (reset_n=0 at clock edge): all outputs 0. FIFO empty, sample and write counters 0, state IDLE.
- mainState != RECORD_STATE: same clear as reset on the next edge, from any state. inputValid drops within 1 cycle. An accepted-but-unfinished write is abandoned.
- States:
  - IDLE: when mainState == RECORD_STATE, go to CAPTURE.
  - CAPTURE: normal operation; write engine active.
  - DONE: stateComplete=1; hold until mainState changes.
  - FAIL: stateFailed=1; inputValid=0; hold until mainState changes.
- Capture:
  - In CAPTURE, on sample_strobe with captured < RECORD_SAMPLES, push inputData into the FIFO and increment captured.
  - Strobes after RECORD_SAMPLES captures are ignored.
  - Strobes in IDLE, DONE or FAIL are ignored.
- Overflow: a push while the FIFO is full and no pop occurs that cycle sends the block to FAIL next cycle. The sample is discarded.
- Write engine:
  - When inputValid=0, FIFO non-empty and isBusy=0, next cycle drive inputValid=1, isWriting=1, writeData=FIFO head, inputAddress=BASE_ADDR+written.
  - Hold all command outputs stable until sdram_recievedCommand=1.
  - On that edge: deassert inputValid, pop the FIFO, increment written.
  - At most one command per 2 cycles (one idle cycle after each acceptance).
- Simultaneous push and pop in the same cycle: legal at any occupancy, including full (no overflow). Occupancy is unchanged.
- Completion: when written == RECORD_SAMPLES, go to DONE on the same edge as the final acceptance. stateComplete asserts on the following cycle's output.
- Widths: counters are 19 bits and saturate at RECORD_SAMPLES. Address = BASE_ADDR + zero-extended written; no wrap.
- Latency: strobe to inputValid rise is 2 cycles when the FIFO was empty and isBusy=0.

Decomposition:
- music_box_pkg holds the mainState encodings (RECORD_STATE, PLAYBACK_STATE), the record_state_t enum (IDLE/CAPTURE/DONE/FAIL) and the SAMPLES_PER_SECOND=22050 constant, so the playback block uses the same length.
- Sub-module sample_fifo: synchronous FIFO, parameterised width/depth. Ports: push, pop, din, dout, full, empty, with the same clock and synchronous reset_n.

Test Plan:
1. RECORD_SAMPLES=8, isBusy=0, recievedCommand echoes inputValid 1 cycle later, strobe every 20 cycles with data 16'h1000+n -> addresses 0..7 written with 0x1000..0x1007 in order; stateComplete=1 after the 8th acceptance; no FAIL.
2. Strobe, hold recievedCommand=0 for 10 cycles -> address and data stable for all 10 cycles while inputValid=1; pop happens only on the acceptance cycle.
3. isBusy=1 for 200 cycles with strobe every 10 cycles, FIFO_DEPTH=4 -> 5th strobe causes overflow; stateFailed=1 next cycle; inputValid=0.
4. FIFO full, acceptance coincides with a strobe -> no overflow; occupancy stays 4; the written sequence is correct.
5. mainState switches away mid-command (inputValid=1) -> next cycle all outputs 0. On re-entry, recording restarts at BASE_ADDR.
6. reset_n=0 for 1 cycle during CAPTURE -> outputs 0 after that edge; the block re-enters CAPTURE afterwards because mainState is still RECORD_STATE.
